// File: rtl/defast_nm_dict_pkg.sv
// Shared constants for the multi-message FAST head decoder.
// Holds default field/presence-map widths, the fixed time and spacer widths
// of the decoded message layout, a default (all-zero) message constant and
// the function that derives the decoded message width.
package defast_nm_dict_pkg;

    localparam int unsigned DEF_PMAP_BITS  = 16;
    localparam int unsigned DEF_FIELD_BITS = 8;
    localparam int unsigned TIME_BITS      = 32;
    localparam int unsigned SPC0_BITS      = 8;   // spacer between head fields and time
    localparam int unsigned SPC1_BITS      = 32;  // spacer after time
    localparam int unsigned DEF_MSG_BITS   = 280;

    localparam logic [DEF_MSG_BITS-1:0] DEF_MSG = '0;

    // Decoded message width: head fields, spacer, time, spacer, trailing pad.
    function automatic int unsigned msg_bits(input int unsigned num_copy,
                                             input int unsigned field_bits,
                                             input int unsigned pad_bits);
        return num_copy * field_bits + SPC0_BITS + TIME_BITS + SPC1_BITS + pad_bits;
    endfunction

endpackage

// File: rtl/defast_nm_chan.sv
// Single-channel FAST head decoder (purely combinational).
// Ports:
//   fast_i  - one FAST message, presence map in the MSBs
//   dict_i  - dictionary seen by this channel, field0 in the MSBs
//   msg_o   - decoded fixed-layout message (all zeros when the map is illegal)
//   err_o   - presence map is illegal
//   dict_o  - dictionary after this channel (unchanged when illegal)
module defast_nm_chan
    import defast_nm_dict_pkg::*;
#(
    parameter int unsigned NUM_COPY   = 3,
    parameter int unsigned FIELD_BITS = DEF_FIELD_BITS,
    parameter int unsigned PMAP_BITS  = DEF_PMAP_BITS,
    parameter int unsigned FAST_BITS  = 344,
    parameter int unsigned PAD_BITS   = 184,
    localparam int unsigned MSG_BITS  = msg_bits(NUM_COPY, FIELD_BITS, PAD_BITS),
    localparam int unsigned DICT_BITS = NUM_COPY * FIELD_BITS
) (
    input  logic [FAST_BITS-1:0] fast_i,
    input  logic [DICT_BITS-1:0] dict_i,
    output logic [MSG_BITS-1:0]  msg_o,
    output logic                 err_o,
    output logic [DICT_BITS-1:0] dict_o
);

    localparam int unsigned STREAM_BITS = FAST_BITS - PMAP_BITS;

    logic [PMAP_BITS-1:0]   pmap;
    logic                   legal;
    logic [DICT_BITS-1:0]   dec_dict;
    logic [TIME_BITS-1:0]   time_val;
    logic [MSG_BITS-1:0]    dec_msg;
    // strm[k] is the byte stream left-aligned so that field k's byte (if any) is on top.
    logic [STREAM_BITS-1:0] strm [NUM_COPY+1];

    assign pmap  = fast_i[FAST_BITS-1 -: PMAP_BITS];
    assign legal = pmap[PMAP_BITS-1] && (pmap[PMAP_BITS-NUM_COPY-2:0] == '0);

    assign strm[0] = fast_i[STREAM_BITS-1:0];

    for (genvar k = 0; k < NUM_COPY; k++) begin : g_field
        logic copy;
        assign copy = pmap[PMAP_BITS-2-k];
        assign dec_dict[DICT_BITS-1-k*FIELD_BITS -: FIELD_BITS] =
            copy ? dict_i[DICT_BITS-1-k*FIELD_BITS -: FIELD_BITS]
                 : strm[k][STREAM_BITS-1 -: FIELD_BITS];
        // Only an explicit field consumes a stream byte.
        assign strm[k+1] = copy ? strm[k] : (strm[k] << FIELD_BITS);
    end

    assign time_val = strm[NUM_COPY][STREAM_BITS-1 -: TIME_BITS];
    assign dec_msg  = {dec_dict, {SPC0_BITS{1'b0}}, time_val, {SPC1_BITS{1'b0}},
                       {PAD_BITS{1'b0}}};

    assign msg_o  = legal ? dec_msg : '0;
    assign err_o  = !legal;
    assign dict_o = legal ? dec_dict : dict_i;

endmodule

// File: rtl/defast_nm_dict.sv
// Multi-message FAST head decoder with an internal copy-operator dictionary.
// Decodes NUM_CH messages per beat; channel c sees the dictionary as updated
// by the legal, present channels below it. One-deep registered output stage
// with valid/ready handshake.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input beat handshake
//   in_mask, in_fast    - per-channel present flags and FAST messages (ch0 in LSBs)
//   dict_load/dict_data - dictionary preset (field0 in MSBs)
//   out_valid/out_ready - output beat handshake
//   out_mask, out_err   - registered mask and per-channel illegal-map flags
//   out_msg             - decoded messages (ch0 in LSBs)
//   dict_q              - current dictionary
// Build option: define DEFAST_STATS_EN to add saturating per-channel
//   counters stat_msg_cnt / stat_err_cnt (16 bits per channel).
module defast_nm_dict
    import defast_nm_dict_pkg::*;
#(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned NUM_COPY   = 3,
    parameter int unsigned FIELD_BITS = DEF_FIELD_BITS,
    parameter int unsigned PMAP_BITS  = DEF_PMAP_BITS,
    parameter int unsigned FAST_BITS  = 344,
    parameter int unsigned PAD_BITS   = 184,
    localparam int unsigned MSG_BITS  = msg_bits(NUM_COPY, FIELD_BITS, PAD_BITS),
    localparam int unsigned DICT_BITS = NUM_COPY * FIELD_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH-1:0]             in_mask,
    input  logic [NUM_CH*FAST_BITS-1:0]   in_fast,
    input  logic                          dict_load,
    input  logic [DICT_BITS-1:0]          dict_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH-1:0]             out_mask,
    output logic [NUM_CH-1:0]             out_err,
    output logic [NUM_CH*MSG_BITS-1:0]    out_msg,
    output logic [DICT_BITS-1:0]          dict_q
`ifdef DEFAST_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]          stat_msg_cnt,
    output logic [NUM_CH*16-1:0]          stat_err_cnt
`endif
);

    logic                       accept;
    logic [DICT_BITS-1:0]       chain [NUM_CH+1];
    logic [NUM_CH-1:0]          ch_err;
    logic [NUM_CH-1:0]          err_d;
    logic [NUM_CH*MSG_BITS-1:0] msg_d;

    logic                       out_valid_q;
    logic [NUM_CH-1:0]          mask_q;
    logic [NUM_CH-1:0]          err_q;
    logic [NUM_CH*MSG_BITS-1:0] msg_q;
    logic [DICT_BITS-1:0]       dict_reg_q;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign chain[0] = dict_reg_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        logic [MSG_BITS-1:0]  ch_msg;
        logic [DICT_BITS-1:0] ch_dict;

        defast_nm_chan #(
            .NUM_COPY   (NUM_COPY),
            .FIELD_BITS (FIELD_BITS),
            .PMAP_BITS  (PMAP_BITS),
            .FAST_BITS  (FAST_BITS),
            .PAD_BITS   (PAD_BITS)
        ) u_chan (
            .fast_i (in_fast[c*FAST_BITS +: FAST_BITS]),
            .dict_i (chain[c]),
            .msg_o  (ch_msg),
            .err_o  (ch_err[c]),
            .dict_o (ch_dict)
        );

        // Masked-off channels are transparent to the dictionary chain.
        assign chain[c+1]                      = in_mask[c] ? ch_dict : chain[c];
        assign msg_d[c*MSG_BITS +: MSG_BITS]   = in_mask[c] ? ch_msg : '0;
        assign err_d[c]                        = in_mask[c] & ch_err[c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            mask_q      <= '0;
            err_q       <= '0;
            msg_q       <= '0;
            dict_reg_q  <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                mask_q      <= in_mask;
                err_q       <= err_d;
                msg_q       <= msg_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            // A preset overrides the chain result of a beat accepted in the same cycle.
            if (dict_load) begin
                dict_reg_q <= dict_data;
            end else if (accept) begin
                dict_reg_q <= chain[NUM_CH];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_mask  = mask_q;
    assign out_err   = err_q;
    assign out_msg   = msg_q;
    assign dict_q    = dict_reg_q;

`ifdef DEFAST_STATS_EN
    logic [15:0] msg_cnt_q [NUM_CH];
    logic [15:0] err_cnt_q [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                msg_cnt_q[c] <= '0;
                err_cnt_q[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_mask[c] && !ch_err[c] && (msg_cnt_q[c] != 16'hFFFF)) begin
                    msg_cnt_q[c] <= msg_cnt_q[c] + 16'd1;
                end
                if (err_d[c] && (err_cnt_q[c] != 16'hFFFF)) begin
                    err_cnt_q[c] <= err_cnt_q[c] + 16'd1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
        assign stat_msg_cnt[c*16 +: 16] = msg_cnt_q[c];
        assign stat_err_cnt[c*16 +: 16] = err_cnt_q[c];
    end
`endif

endmodule

// File: tb/tb_defast_nm_dict.sv
module tb_defast_nm_dict;
    import defast_nm_dict_pkg::*;

    localparam int NCH  = 3;
    localparam int FB   = 8;
    localparam int PB   = 16;
    localparam int FAST = 344;
    localparam int PAD  = 184;
    localparam int MB   = 3 * FB + 72 + PAD;
    localparam int DB   = 3 * FB;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [NCH-1:0]        in_mask;
    logic [NCH*FAST-1:0]   in_fast;
    logic                  dict_load;
    logic [DB-1:0]         dict_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [NCH-1:0]        out_mask;
    logic [NCH-1:0]        out_err;
    logic [NCH*MB-1:0]     out_msg;
    logic [DB-1:0]         dict_q;
`ifdef DEFAST_STATS_EN
    logic [NCH*16-1:0]     stat_msg_cnt;
    logic [NCH*16-1:0]     stat_err_cnt;
`endif

    defast_nm_dict #(
        .NUM_CH     (NCH),
        .NUM_COPY   (3),
        .FIELD_BITS (FB),
        .PMAP_BITS  (PB),
        .FAST_BITS  (FAST),
        .PAD_BITS   (PAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_fast   (in_fast),
        .dict_load (dict_load),
        .dict_data (dict_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_err   (out_err),
        .out_msg   (out_msg),
        .dict_q    (dict_q)
`ifdef DEFAST_STATS_EN
        ,
        .stat_msg_cnt (stat_msg_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            load;
        logic [23:0]     ldata;
        logic [2:0]      mask;
        logic [2:0][15:0] p;
        logic [2:0][23:0] eb;   // explicit stream bytes, first byte in MSBs
        logic [2:0][1:0]  n;    // number of explicit bytes
        logic [2:0][31:0] tm;
        logic [2:0]      err;
        logic [2:0][23:0] head;
        logic [23:0]     dict;
    } vec_t;

    typedef struct {
        logic [2:0]        mask;
        logic [2:0]        err;
        logic [2:0][MB-1:0] msg;
        logic [23:0]       dict;
        bit                chk_dict;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [FAST-1:0] mk_fast(input logic [15:0] p, input logic [23:0] eb,
                                                input logic [1:0] n, input logic [31:0] tm);
        logic [FAST-PB-1:0] s;
        s = '0;
        for (int i = 0; i < int'(n); i++) s[FAST-PB-1-8*i -: 8] = eb[23-8*i -: 8];
        s[FAST-PB-1-8*int'(n) -: 32] = tm;
        return {p, s};
    endfunction

    function automatic logic [MB-1:0] mk_msg(input logic [23:0] h, input logic [31:0] tm);
        return {h, 8'h00, tm, 32'h0, {PAD{1'b0}}};
    endfunction

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_mask   = v.mask;
        dict_load = v.load;
        dict_data = v.ldata;
        for (int c = 0; c < NCH; c++)
            in_fast[c*FAST +: FAST] = mk_fast(v.p[c], v.eb[c], v.n[c], v.tm[c]);
    endtask

    function automatic exp_t mk_exp(input vec_t v, input bit chk_dict);
        exp_t e;
        e.mask = v.mask;
        e.err = v.err;
        e.dict = v.dict;
        e.chk_dict = chk_dict;
        for (int c = 0; c < NCH; c++)
            e.msg[c] = (v.mask[c] && !v.err[c]) ? mk_msg(v.head[c], v.tm[c]) : '0;
        return e;
    endfunction

    // Drive one beat, wait (bounded) for acceptance, check 1-cycle latency.
    task automatic send(input vec_t v, input bit chk_dict);
        int w;
        drive(v);
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) begin
            check("accept_timeout", {{(MB-1){1'b0}}, in_ready}, 1);
            in_valid = 1'b0;
            dict_load = 1'b0;
        end else begin
            sb.push_back(mk_exp(v, chk_dict));
            @(posedge clk); #1;
            in_valid = 1'b0;
            dict_load = 1'b0;
            check("latency_valid", {{(MB-1){1'b0}}, out_valid}, 1);
        end
    endtask

    // Scoreboard: compare the visible beat just before it is taken downstream.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", {{(MB-1){1'b0}}, out_valid}, 0);
            end else begin
                e = sb.pop_front();
                check("out_mask", {{(MB-3){1'b0}}, out_mask}, {{(MB-3){1'b0}}, e.mask});
                check("out_err", {{(MB-3){1'b0}}, out_err}, {{(MB-3){1'b0}}, e.err});
                for (int c = 0; c < NCH; c++)
                    check($sformatf("out_msg%0d", c), out_msg[c*MB +: MB], e.msg[c]);
                if (e.chk_dict)
                    check("dict_q", {{(MB-24){1'b0}}, dict_q}, {{(MB-24){1'b0}}, e.dict});
            end
        end
    end

    vec_t tbl[8];
    vec_t va, vb, vc, vr;
`ifdef DEFAST_STATS_EN
    vec_t vs;
`endif

    initial begin
        tbl[0] = '{load:1'b1, ldata:24'h112233, mask:3'b000, p:'0, eb:'0, n:'0, tm:'0,
                   err:3'b000, head:'0, dict:24'h112233};
        tbl[1] = '{load:1'b0, ldata:'0, mask:3'b001, p:{16'h0, 16'h0, 16'hF000}, eb:'0, n:'0,
                   tm:{32'h0, 32'h0, 32'hDEADBEEF}, err:3'b000,
                   head:{24'h0, 24'h0, 24'h112233}, dict:24'h112233};
        tbl[2] = '{load:1'b0, ldata:'0, mask:3'b011, p:{16'h0, 16'hF000, 16'h8000},
                   eb:{24'h0, 24'h0, 24'hA1A2A3}, n:{2'd0, 2'd0, 2'd3},
                   tm:{32'h0, 32'h89ABCDEF, 32'h01234567}, err:3'b000,
                   head:{24'h0, 24'hA1A2A3, 24'hA1A2A3}, dict:24'hA1A2A3};
        tbl[3] = '{load:1'b0, ldata:'0, mask:3'b010, p:{16'h0, 16'h9001, 16'h8000},
                   eb:{24'h0, 24'h0, 24'h556677}, n:{2'd0, 2'd0, 2'd3}, tm:'0, err:3'b010,
                   head:'0, dict:24'hA1A2A3};
        tbl[4] = '{load:1'b0, ldata:'0, mask:3'b111, p:{16'hC000, 16'h7000, 16'hA000},
                   eb:{24'hC1C200, 24'h0, 24'hB0B200}, n:{2'd2, 2'd0, 2'd2},
                   tm:{32'h22222222, 32'h0, 32'h11111111}, err:3'b010,
                   head:{24'hB0C1C2, 24'h0, 24'hB0A2B2}, dict:24'hB0C1C2};
        tbl[5] = '{load:1'b1, ldata:24'h010203, mask:3'b001, p:{16'h0, 16'h0, 16'hF000},
                   eb:'0, n:'0, tm:{32'h0, 32'h0, 32'hCAFEF00D}, err:3'b000,
                   head:{24'h0, 24'h0, 24'hB0C1C2}, dict:24'h010203};
        tbl[6] = '{load:1'b0, ldata:'0, mask:3'b100, p:{16'hF000, 16'h0, 16'h0}, eb:'0, n:'0,
                   tm:{32'h00000001, 32'h0, 32'h0}, err:3'b000,
                   head:{24'h010203, 24'h0, 24'h0}, dict:24'h010203};
        tbl[7] = '{load:1'b0, ldata:'0, mask:3'b111, p:{16'h8000, 16'hF800, 16'h8800},
                   eb:{24'hD1D2D3, 24'h0, 24'h0}, n:{2'd3, 2'd0, 2'd0},
                   tm:{32'h33333333, 32'h0, 32'h0}, err:3'b011,
                   head:{24'hD1D2D3, 24'h0, 24'h0}, dict:24'hD1D2D3};
        va = '{load:1'b0, ldata:'0, mask:3'b001, p:{16'h0, 16'h0, 16'hF000}, eb:'0, n:'0,
               tm:{32'h0, 32'h0, 32'h44444444}, err:3'b000,
               head:{24'h0, 24'h0, 24'hD1D2D3}, dict:'0};
        vb = '{load:1'b0, ldata:'0, mask:3'b001, p:{16'h0, 16'h0, 16'hF000}, eb:'0, n:'0,
               tm:{32'h0, 32'h0, 32'h55555555}, err:3'b000,
               head:{24'h0, 24'h0, 24'hABCDEF}, dict:24'hABCDEF};
        vc = '{load:1'b0, ldata:'0, mask:3'b001, p:{16'h0, 16'h0, 16'h8000},
               eb:{24'h0, 24'h0, 24'h999999}, n:{2'd0, 2'd0, 2'd3},
               tm:{32'h0, 32'h0, 32'h66666666}, err:3'b000,
               head:{24'h0, 24'h0, 24'h999999}, dict:24'h999999};
        vr = '{load:1'b0, ldata:'0, mask:3'b001, p:{16'h0, 16'h0, 16'hF000}, eb:'0, n:'0,
               tm:{32'h0, 32'h0, 32'h77777777}, err:3'b000, head:'0, dict:24'h0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_mask = '0;
        in_fast = '0;
        dict_load = 1'b0;
        dict_data = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {{(MB-1){1'b0}}, out_valid}, 0);
        check("rst_in_ready", {{(MB-1){1'b0}}, in_ready}, 1);
        check("rst_out_mask", {{(MB-3){1'b0}}, out_mask}, 0);
        check("rst_out_err", {{(MB-3){1'b0}}, out_err}, 0);
        check("rst_out_msg0", out_msg[MB-1:0], 0);
        check("rst_dict_q", {{(MB-24){1'b0}}, dict_q}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) send(tbl[i], 1'b1);
        @(posedge clk); #1;

        // Output stall with a second beat waiting and a preset during the stall.
        out_ready = 1'b0;
        send(va, 1'b0);
        drive(vb);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                dict_load = 1'b1;
                dict_data = 24'hABCDEF;
            end
            @(negedge clk);
            check("stall_in_ready", {{(MB-1){1'b0}}, in_ready}, 0);
            check("stall_out_msg0", out_msg[MB-1:0], mk_msg(24'hD1D2D3, 32'h44444444));
            @(posedge clk); #1;
            dict_load = 1'b0;
        end
        check("stall_dict_load", {{(MB-24){1'b0}}, dict_q}, {{(MB-24){1'b0}}, 24'hABCDEF});
        out_ready = 1'b1;
        sb.push_back(mk_exp(vb, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_stall_valid", {{(MB-1){1'b0}}, out_valid}, 1);
        @(posedge clk); #1;

        // Reset while a beat is held drops it and clears the dictionary.
        out_ready = 1'b0;
        send(vc, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", {{(MB-1){1'b0}}, out_valid}, 0);
        check("midrst_dict_q", {{(MB-24){1'b0}}, dict_q}, 0);
        check("midrst_out_msg0", out_msg[MB-1:0], 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(vr, 1'b1);
        @(posedge clk); #1;

`ifdef DEFAST_STATS_EN
        vs = '{load:1'b0, ldata:'0, mask:3'b100, p:{16'hF000, 16'h0, 16'h0}, eb:'0, n:'0,
               tm:{32'h12345678, 32'h0, 32'h0}, err:3'b000, head:'0, dict:24'h0};
        for (int i = 0; i < 70000; i++) send(vs, 1'b1);
        @(posedge clk); #1;
        check("stat_msg_ch2", {{(MB-16){1'b0}}, stat_msg_cnt[47:32]}, {{(MB-16){1'b0}}, 16'hFFFF});
        check("stat_msg_ch0", {{(MB-16){1'b0}}, stat_msg_cnt[15:0]}, 1);
        check("stat_err_ch2", {{(MB-16){1'b0}}, stat_err_cnt[47:32]}, 0);
`endif

        for (int w = 0; w < 10 && sb.size() != 0; w++) begin
            @(posedge clk); #1;
        end
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/defast_nm_dict.md
Name: defast_nm_dict

Overview:
- Parametrised successor to the stage-4 FAST head decoder for N-message beats.
- Decodes NUM_CH FAST-encoded messages per beat into fixed-layout messages, resolving copy-operator head fields against an internal dictionary rather than external field registers.
- Dictionary updates in channel order within a beat; valid/ready handshake; registered output. Sits between stage-3 field extraction and the stage-5 message buffer.

Parameters:
- NUM_CH, 3, messages per beat.
- NUM_COPY, 3, copy-operator head fields (PID, MC, MT, ...), each FIELD_BITS wide.
- FIELD_BITS, 8, width of one head field / stream byte.
- PMAP_BITS, 16, presence-map width at the MSB end of each fast message.
- FAST_BITS, 344, fast message width; must satisfy FAST_BITS-PMAP_BITS >= NUM_COPY*FIELD_BITS+32.
- PAD_BITS, 184, trailing zero pad.
- MSG_BITS, derived: NUM_COPY*FIELD_BITS+72+PAD_BITS (280 at defaults).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- in_mask  in  NUM_CH  per-channel message present
- in_fast  in  NUM_CH*FAST_BITS  fast messages, ch0 in LSBs
- dict_load  in  1  preset dictionary
- dict_data  in  NUM_COPY*FIELD_BITS  preset value, field0 in MSBs
- out_valid  out  1  decoded beat valid
- out_ready  in  1  downstream accept
- out_mask  out  NUM_CH  registered in_mask
- out_err  out  NUM_CH  illegal presence map on channel
- out_msg  out  NUM_CH*MSG_BITS  decoded messages
- dict_q  out  NUM_COPY*FIELD_BITS  current dictionary

Behaviour:
- Reset: out_valid=0, out_mask=0, out_err=0, out_msg=0, dictionary=0; in_ready=1 after reset.
- Handshake: in_ready = !out_valid || out_ready. Accepted beat appears on outputs next cycle (latency 1). Output held stable while out_valid&&!out_ready. No combinational in_valid->out path.
- Presence map P = fast[FAST_BITS-1 -: PMAP_BITS]. Legal iff P[MSB]=1 and bits below the top NUM_COPY+1 are all 0.
- For field k (k=0 is PID), P[MSB-1-k]=1 selects the dictionary value; otherwise consume the next FIELD_BITS byte from the stream. The stream starts at bit FAST_BITS-PMAP_BITS-1, field k before k+1.
- After head fields, consume 32 time bits.
- Output layout MSB->LSB: fields 0..NUM_COPY-1, 8'b0, time, 32'b0, PAD_BITS zeros.
- Illegal map: out_msg channel = all zeros, out_err bit=1, no dictionary update.
- Masked-off channel: out_msg=0, out_err=0, no dictionary update.
- Dictionary chain: channel c decodes using the dictionary as updated by legal, present channels 0..c-1 of the same beat. After channel c decodes, every field it decoded (copied or explicit) is written to the dictionary. Final chain value registers on accept.
- dict_load: dictionary<=dict_data. If a beat is accepted in the same cycle, that beat decodes with the pre-load chain, but the load value wins the register. dict_load during output stall is still applied.
- Reset mid-stall drops the held beat; dictionary returns to 0.

Optional Feature:
- DEFAST_STATS_EN defined: adds outputs stat_msg_cnt and stat_err_cnt, each NUM_CH*16.
  - stat_msg_cnt increments per accepted legal present channel; stat_err_cnt increments per accepted illegal present channel.
  - Both are saturating at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package (para_def include): PMAP_BITS, FIELD_BITS, time width 32, spacer widths 8/32, default-message constant, MSG_BITS derivation function.
- One sub-module: defast_nm_chan. Purely combinational, one channel. Inputs: fast message, dictionary-in. Outputs: message, err, dictionary-out.
- Top instantiates NUM_CH copies in a generate chain and holds the registers, handshake and stats.

Test Plan:
- Reset then ch0 P=16'hF000, time=32'hDEADBEEF, dictionary preset 0x11/0x22/0x33 -> out_msg0 head 11 22 33, time DEADBEEF, err=0, one cycle after accept.
- ch0 P=16'h8000 bytes 0xA1,0xA2,0xA3; ch1 P=16'hF000 same beat -> ch1 head A1 A2 A3 (intra-beat chain); dict_q=A1A2A3 next cycle.
- ch1 P=16'h9001 (low bit set) -> out_err=3'b010, out_msg1=0, dictionary unchanged.
- out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_msg stable, second beat accepted the cycle after out_ready=1.
- dict_load=1 with data 0x010203 and accepted beat ch0 P=16'hF000 in the same cycle -> output uses old dictionary, dict_q=010203 next cycle.
- DEFAST_STATS_EN: 70000 legal ch2 messages -> stat_msg_cnt[ch2]=16'hFFFF, no wrap.
